// File: rtl/xor_frame_parity_if.sv
// Purpose : handshake bundle for xor_frame_parity.
//           Input side carries a WIDTH-bit word stream with frame delimiter and
//           mode. Output side carries one parity result per frame.
// Modports: master - the environment (word producer + result consumer)
//           slave  - the parity engine
// Signals : in_valid/in_ready/in_data/in_last/mode  word stream
//           out_valid/out_ready/out_colpar/out_rowpar/out_len/out_err  result
interface xor_frame_parity_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_colpar;
  logic             out_rowpar;
  logic [LW-1:0]    out_len;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_colpar, out_rowpar, out_len, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_colpar, out_rowpar, out_len, out_err
  );
endinterface

// File: rtl/xor_frame_parity.sv
// Purpose : streaming XOR parity engine. Accumulates column parity over a frame
//           of WIDTH-bit words and emits colpar, rowpar, length and error once
//           per frame. Generate mode reports parity; check mode treats the last
//           word as expected parity, so colpar becomes the syndrome.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           bus  - xor_frame_parity_if.slave (word stream in, result out)
// Notes   : all result outputs are registered; in_ready is decoded from the
//           state and rst so the block never accepts a word during reset.
module xor_frame_parity #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned ODD     = 0
) (
  input  logic              clk,
  input  logic              rst,
  xor_frame_parity_if.slave bus
);

  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam logic        ODD_BIT = 1'(ODD);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;

  // Frame accumulation state
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             fmode_q, fmode_d;

  // Result registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] colpar_q, colpar_d;
  logic             rowpar_q, rowpar_d;
  logic [LW-1:0]    len_q, len_d;
  logic             err_q, err_d;

  // Per-word update values, used both for accumulation and for the final result
  logic             in_ready_c;
  logic             in_fire_c;
  logic             out_fire_c;
  logic             cnt_sat_c;
  logic [WIDTH-1:0] acc_nx_c;
  logic [LW-1:0]    cnt_nx_c;
  logic             ovf_nx_c;
  logic             fmode_nx_c;

  assign in_ready_c = (state_q == ACC) && !rst;
  assign in_fire_c  = bus.in_valid && in_ready_c;
  assign out_fire_c = out_valid_q && bus.out_ready;

  assign cnt_sat_c  = (cnt_q == LW'(MAX_LEN));
  assign acc_nx_c   = acc_q ^ bus.in_data;
  assign cnt_nx_c   = cnt_sat_c ? cnt_q : cnt_q + LW'(1);
  // A word arriving with the counter already full is the overflow event
  assign ovf_nx_c   = ovf_q | cnt_sat_c;
  // Mode is only sampled with the first word of a frame
  assign fmode_nx_c = (cnt_q == '0) ? bus.mode : fmode_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      fmode_q     <= 1'b0;
      out_valid_q <= 1'b0;
      colpar_q    <= '0;
      rowpar_q    <= 1'b0;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      fmode_q     <= fmode_d;
      out_valid_q <= out_valid_d;
      colpar_q    <= colpar_d;
      rowpar_q    <= rowpar_d;
      len_q       <= len_d;
      err_q       <= err_d;
    end
  end

  // Next-state and result decode
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    fmode_d     = fmode_q;
    out_valid_d = out_valid_q;
    colpar_d    = colpar_q;
    rowpar_d    = rowpar_q;
    len_d       = len_q;
    err_d       = err_q;

    case (state_q)
      ACC: begin
        if (in_fire_c) begin
          acc_d   = acc_nx_c;
          cnt_d   = cnt_nx_c;
          ovf_d   = ovf_nx_c;
          fmode_d = fmode_nx_c;
          if (bus.in_last) begin
            // Result includes the last word, including its overflow contribution
            out_valid_d = 1'b1;
            colpar_d    = acc_nx_c;
            rowpar_d    = (^acc_nx_c) ^ ODD_BIT;
            len_d       = cnt_nx_c;
            err_d       = ovf_nx_c | (fmode_nx_c & (|acc_nx_c));
            state_d     = HOLD;
          end
        end
      end

      HOLD: begin
        // Results stay stable and input is ignored until the consumer takes them
        if (out_fire_c) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          fmode_d     = 1'b0;
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end

      default: begin
        state_d = ACC;
      end
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_colpar = colpar_q;
  assign bus.out_rowpar = rowpar_q;
  assign bus.out_len    = len_q;
  assign bus.out_err    = err_q;

endmodule

// File: doc/xor_frame_parity.md
Name: xor_frame_parity

Overview:
Streaming XOR parity engine, parametrised successor to the single-bit XOR gate. It accumulates bitwise XOR (column parity) over a frame of WIDTH-bit words, then emits column parity, a single-bit row parity, the frame length and an error flag. Two modes: generate (emit parity) and check (the last word is the expected parity; flag a mismatch). Sits between a word-stream producer and a consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, data word width in bits (>=1)
MAX_LEN, 16, maximum words per frame before overflow is flagged (>=1)
ODD, 0, row parity sense: 0 = even parity, 1 = odd parity
LW, $clog2(MAX_LEN+1), derived width of the length field (localparam)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block accepts a word this cycle
in_data  in  WIDTH  input word
in_last  in  1  marks the final word of a frame
mode  in  1  0 = generate, 1 = check; sampled with the first word of each frame
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_colpar  out  WIDTH  XOR of all words in the frame
out_rowpar  out  1  ^out_colpar ^ ODD
out_len  out  LW  accepted word count, saturating at MAX_LEN
out_err  out  1  overflow OR (check mode and out_colpar != 0)

Behaviour:
- Word accepted when in_valid && in_ready. Result accepted when out_valid && out_ready.
- FSM with two states: ACC and HOLD.
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- In ACC, on each accepted word:
  - acc <= acc ^ in_data.
  - cnt <= cnt+1, saturating at MAX_LEN.
  - If cnt==MAX_LEN already, set sticky ovf.
  - First word of a frame (cnt==0): latch mode into frame_mode.
- Accepted word with in_last=1: register results into the output registers and go to HOLD. out_valid is high the next cycle, so latency is 1 cycle from the last word to the result.
- A single-word frame (first word carries in_last) is legal.
- HOLD:
  - Outputs stay stable until out_ready.
  - in_data, in_valid, in_last and mode are ignored; no word is accepted.
  - On result accept: clear acc, cnt, ovf and frame_mode; return to ACC. in_ready is high the following cycle (no same-cycle bypass).
- Check mode: err = ovf || (acc_final != 0), where acc_final includes the last word. out_colpar reports acc_final, i.e. the syndrome.
- Generate mode: err = ovf.
- out_len counts every accepted word including the last, saturating at MAX_LEN.
- Reset (any state, including mid-frame or in HOLD):
  - Next cycle: acc=0, cnt=0, ovf=0, state=ACC.
  - Outputs: out_valid=0, out_colpar=0, out_rowpar=0, out_len=0, out_err=0.
  - in_ready=0 while rst is high, 1 on the first cycle after rst deasserts.
  - A partial frame is discarded; no result is emitted for it.
- Changing mode mid-frame has no effect; only the value sampled with the first word applies.
- All outputs are registered except in_ready, which is decoded from state and rst.

Test Plan:
1. Generate, WIDTH=8, ODD=0: words 0x0F, 0xF0, 0x55(last) back-to-back -> one cycle later out_valid=1, colpar=0xAA, rowpar=0, len=3, err=0.
2. Check mode: 0x12, 0x34, 0x26(last) -> colpar=0x00, err=0. Repeat with last=0x27 -> colpar=0x01, err=1, rowpar=1.
3. Backpressure: after frame 1, hold out_ready=0 for 5 cycles while driving in_valid=1 with 0xFF -> outputs constant, in_ready=0, no word counted. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle; the next frame starts from acc=0.
4. Overflow, MAX_LEN=4: six words 0x01 each, last on the 6th -> len=4, err=1, colpar=0x00.
5. Reset mid-frame: words 0xAA, 0x55, then rst for 1 cycle, then 0x3C(last) -> colpar=0x3C, len=1, err=0. Reset asserted in HOLD -> out_valid=0 next cycle.
6. Single-word frame 0x80(last): ODD=0 -> rowpar=1, len=1; ODD=1 -> rowpar=0. Mode toggled after the first word of a multi-word frame -> the result follows the first-word mode.
